// File: rtl/vblank_update_scheduler.sv
// Shares the vertical-blanking update window between N_REQ game-logic units.
// Round-robin, one time-limited slot per unit per frame, opened by frame_end.
module vblank_update_scheduler #(
  parameter int N_REQ         = 4,
  parameter int WINDOW_CYCLES = 32000,
  parameter int SLOT_MAX      = 4096,
  parameter int FC_WIDTH      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_end,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    done,
  output logic [N_REQ-1:0]    grant,
  output logic                window_active,
  output logic                frame_start,
  output logic [FC_WIDTH-1:0] frame_count,
  output logic                slot_timeout,
  output logic                frame_overrun,
  output logic [N_REQ-1:0]    unserved
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int SLOT_W = $clog2(SLOT_MAX);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_MAX - 1);
  localparam logic [IDX_W:0]    N_WIDE    = (IDX_W+1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  win_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  rr_ptr, rr_next;
  logic [IDX_W-1:0]  gnt_idx, pick_idx;
  logic              pick_valid;
  logic [N_REQ-1:0]  served, served_d, eligible;
  logic              win_close, slot_limit, gnt_done;
  logic [IDX_W:0]    rr_sum;

  assign eligible   = req & ~served;
  assign win_close  = (state_q != IDLE) && (win_cnt == WIN_LAST);
  assign slot_limit = (state_q == GRANT) && (slot_cnt == SLOT_LAST);
  assign gnt_done   = (state_q == GRANT) && done[gnt_idx];

  // First eligible unit at or above rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    logic [IDX_W:0] cand;
    // NOTE: every variable written here gets a default first, so no path infers a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= N_WIDE) cand = cand - N_WIDE;
      if (!pick_valid && eligible[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_sum  = {1'b0, pick_idx} + (IDX_W+1)'(1);
    rr_next = (rr_sum == N_WIDE) ? '0 : rr_sum[IDX_W-1:0];
  end

  // A revoke at window close leaves the unit unserved; done still counts.
  always_comb begin
    served_d = served;
    if (state_q == IDLE && frame_end)
      served_d = '0;
    else if (state_q == GRANT && (gnt_done || (slot_limit && !win_close)))
      served_d[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_end) state_d = ARB;
      ARB: begin
        if (win_close)       state_d = IDLE;
        else if (pick_valid) state_d = GRANT;
      end
      GRANT: begin
        if (win_close)                  state_d = IDLE;
        else if (gnt_done || slot_limit) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    window_active = (state_q != IDLE);
    frame_start   = (state_q == ARB) && (win_cnt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant         <= '0;
      gnt_idx       <= '0;
      rr_ptr        <= '0;
      served        <= '0;
      win_cnt       <= '0;
      slot_cnt      <= '0;
      unserved      <= '0;
      frame_count   <= '0;
      slot_timeout  <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      frame_count   <= frame_count + FC_WIDTH'(frame_end);
      frame_overrun <= frame_end && (state_q != IDLE);
      slot_timeout  <= (state_q == GRANT) && !gnt_done && (slot_limit || win_close);
      served        <= served_d;
      win_cnt       <= (state_q == IDLE || state_d == IDLE) ? '0 : win_cnt + WIN_W'(1);
      slot_cnt      <= (state_q == GRANT && state_d == GRANT) ? slot_cnt + SLOT_W'(1) : '0;

      if (state_q == ARB && state_d == GRANT) begin
        grant   <= N_REQ'(1) << pick_idx;
        gnt_idx <= pick_idx;
        rr_ptr  <= rr_next;
      end else if (state_d != GRANT) begin
        grant <= '0;
      end

      if (win_close) unserved <= req & ~served_d;
    end
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Scoreboarded bench for vblank_update_scheduler: directed frames on a 64-cycle
// and a 16-cycle window instance; a monitor turns DUT activity into transactions.
module tb_vblank_update_scheduler;

  localparam int N = 4;

  typedef enum logic [1:0] {K_GRANT, K_WINDOW} kind_e;
  // GRANT : a=unit b=cycles held c=slot_timeout on release d=idle cycles before
  // WINDOW: a=length b=unserved c=frame_count d=frame_start e=overrun f=timeout pulses
  typedef struct packed {
    kind_e       kind;
    logic [1:0]  dut;
    logic [15:0] a, b, c, d, e, f;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_end_s [2];
  logic [N-1:0] req_s [2], done_s [2], grant_s [2], unserved_s [2];
  logic         wa_s [2], fs_s [2], to_s [2], ov_s [2];
  logic [7:0]   fc_s [2];

  txn_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   lat [2][N];
  int   held [2];

  always #5 clk = ~clk;

  vblank_update_scheduler #(.N_REQ(N), .WINDOW_CYCLES(64), .SLOT_MAX(8), .FC_WIDTH(8)) u_dut_a (
    .clk(clk), .reset(rst), .frame_end(frame_end_s[0]), .req(req_s[0]), .done(done_s[0]),
    .grant(grant_s[0]), .window_active(wa_s[0]), .frame_start(fs_s[0]), .frame_count(fc_s[0]),
    .slot_timeout(to_s[0]), .frame_overrun(ov_s[0]), .unserved(unserved_s[0]));

  vblank_update_scheduler #(.N_REQ(N), .WINDOW_CYCLES(16), .SLOT_MAX(8), .FC_WIDTH(8)) u_dut_b (
    .clk(clk), .reset(rst), .frame_end(frame_end_s[1]), .req(req_s[1]), .done(done_s[1]),
    .grant(grant_s[1]), .window_active(wa_s[1]), .frame_start(fs_s[1]), .frame_count(fc_s[1]),
    .slot_timeout(to_s[1]), .frame_overrun(ov_s[1]), .unserved(unserved_s[1]));

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic string fmt(input txn_t t);
    return $sformatf("%s dut=%0d a=%0d b=%0d c=%0d d=%0d e=%0d f=%0d",
                     (t.kind == K_GRANT) ? "grant" : "window", t.dut, t.a, t.b, t.c, t.d, t.e, t.f);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic compare(input txn_t obs);
    txn_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL txn_unexpected: got {%s} required nothing", fmt(obs));
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL txn: got {%s} required {%s}", fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic push_grant(input int dut, input int unit, input int len, input int to);
    txn_t t;
    t = '0; t.kind = K_GRANT; t.dut = 2'(dut);
    t.a = 16'(unit); t.b = 16'(len); t.c = 16'(to); t.d = 16'd1;
    exp_q.push_back(t);
  endtask

  task automatic push_window(input int dut, input int len, input int uns, input int fc,
                             input int ov, input int to);
    txn_t t;
    t = '0; t.kind = K_WINDOW; t.dut = 2'(dut);
    t.a = 16'(len); t.b = 16'(uns); t.c = 16'(fc); t.d = 16'd1; t.e = 16'(ov); t.f = 16'(to);
    exp_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fe(input int d);
    frame_end_s[d] = 1'b1;
    tick();
    frame_end_s[d] = 1'b0;
  endtask

  task automatic set_lat(input int d, input int l0, input int l1, input int l2, input int l3);
    lat[d][0] = l0; lat[d][1] = l1; lat[d][2] = l2; lat[d][3] = l3;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d outstanding transactions after %0d cycles, required 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  // Unit model: pulse done on the lat-th cycle of its grant; lat 0 never answers.
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst || grant_s[d] == '0) begin
        held[d]   = 0;
        done_s[d] = '0;
      end else begin
        held[d]++;
        done_s[d] = (lat[d][oh_idx(grant_s[d])] == held[d]) ? grant_s[d] : '0;
      end
    end
  end

  int           w_len [2], fs_cnt [2], ov_cnt [2], to_cnt [2], idle_cnt [2];
  int           g_len [2], g_gap [2], g_unit [2];
  logic         win_prev [2];
  logic [N-1:0] g_prev [2];

  always begin
    txn_t t;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        win_prev[d] = 1'b0;
        g_prev[d]   = '0;
        idle_cnt[d] = 0;
      end else begin
        checks++;
        if ($countones(grant_s[d]) > 1 || (grant_s[d] != '0 && !wa_s[d]) || (fs_s[d] && !wa_s[d])) begin
          errors++;
          $display("FAIL legal dut%0d: got grant=%b window_active=%b frame_start=%b, required one-hot-or-zero grant only inside window",
                   d, grant_s[d], wa_s[d], fs_s[d]);
        end
        if (wa_s[d] && !win_prev[d]) begin
          w_len[d] = 0; fs_cnt[d] = 0; ov_cnt[d] = 0; to_cnt[d] = 0; idle_cnt[d] = 0;
        end
        if (wa_s[d] || win_prev[d]) begin
          fs_cnt[d] += int'(fs_s[d]);
          ov_cnt[d] += int'(ov_s[d]);
          to_cnt[d] += int'(to_s[d]);
        end
        if (wa_s[d]) w_len[d]++;
        if (grant_s[d] != '0 && g_prev[d] == '0) begin
          g_gap[d]  = idle_cnt[d];
          g_len[d]  = 0;
          g_unit[d] = oh_idx(grant_s[d]);
        end
        if (grant_s[d] == '0 && g_prev[d] != '0) begin
          t = '0; t.kind = K_GRANT; t.dut = 2'(d);
          t.a = 16'(g_unit[d]); t.b = 16'(g_len[d]); t.c = 16'(to_s[d]); t.d = 16'(g_gap[d]);
          compare(t);
        end
        if (grant_s[d] != '0) begin
          g_len[d]++;
          idle_cnt[d] = 0;
        end else if (wa_s[d]) begin
          idle_cnt[d]++;
        end
        if (!wa_s[d] && win_prev[d]) begin
          t = '0; t.kind = K_WINDOW; t.dut = 2'(d);
          t.a = 16'(w_len[d]); t.b = 16'(unserved_s[d]); t.c = 16'(fc_s[d]);
          t.d = 16'(fs_cnt[d]); t.e = 16'(ov_cnt[d]); t.f = 16'(to_cnt[d]);
          compare(t);
        end
        win_prev[d] = wa_s[d];
        g_prev[d]   = grant_s[d];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      frame_end_s[d] = 1'b0;
      req_s[d]       = '0;
      set_lat(d, 3, 3, 3, 3);
    end
    #1 rst = 1'b1;
    #2;
    check("reset_grant", grant_s[0], 0);
    check("reset_window_active", wa_s[0], 0);
    check("reset_frame_start", fs_s[0], 0);
    check("reset_frame_count", fc_s[0], 0);
    check("reset_slot_timeout", to_s[0], 0);
    check("reset_frame_overrun", ov_s[0], 0);
    check("reset_unserved", unserved_s[0], 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: all units answer on their third grant cycle
    req_s[0] = 4'b1111;
    for (int u = 0; u < N; u++) push_grant(0, u, 3, 0);
    push_window(0, 64, 0, 1, 0, 0);
    pulse_fe(0);
    wait_drain("t1");

    // 2: unit 1 silent, revoked after SLOT_MAX cycles
    set_lat(0, 3, 0, 3, 3);
    push_grant(0, 0, 3, 0);
    push_grant(0, 1, 8, 1);
    push_grant(0, 2, 3, 0);
    push_grant(0, 3, 3, 0);
    push_window(0, 64, 0, 2, 0, 1);
    pulse_fe(0);
    wait_drain("t2");

    // 3: lone unit 2, then the pointer continues from unit 3
    set_lat(0, 3, 3, 3, 3);
    req_s[0] = 4'b0100;
    push_grant(0, 2, 3, 0);
    push_window(0, 64, 0, 3, 0, 0);
    pulse_fe(0);
    wait_drain("t3a");
    req_s[0] = 4'b1011;
    push_grant(0, 3, 3, 0);
    push_grant(0, 0, 3, 0);
    push_grant(0, 1, 3, 0);
    push_window(0, 64, 0, 4, 0, 0);
    pulse_fe(0);
    wait_drain("t3b");

    // 4: short window, nobody answers; unit 1 cut off at window close
    req_s[1] = 4'b0011;
    set_lat(1, 0, 0, 0, 0);
    push_grant(1, 0, 8, 1);
    push_grant(1, 1, 6, 1);
    push_window(1, 16, 4'b0010, 1, 0, 2);
    pulse_fe(1);
    wait_drain("t4a");

    // 4b: last done lands on the window-close cycle
    req_s[1] = 4'b1111;
    set_lat(1, 3, 3, 3, 3);
    push_grant(1, 2, 3, 0);
    push_grant(1, 3, 3, 0);
    push_grant(1, 0, 3, 0);
    push_grant(1, 1, 3, 0);
    push_window(1, 16, 0, 2, 0, 0);
    pulse_fe(1);
    wait_drain("t4b");

    // 5a: second frame_end ten cycles after the first
    req_s[0] = 4'b1111;
    push_grant(0, 2, 3, 0);
    push_grant(0, 3, 3, 0);
    push_grant(0, 0, 3, 0);
    push_grant(0, 1, 3, 0);
    push_window(0, 64, 0, 6, 1, 0);
    pulse_fe(0);
    repeat (9) tick();
    pulse_fe(0);
    wait_drain("t5a");

    // 5b: frame_end on the closing cycle is counted but does not reopen
    push_grant(0, 2, 3, 0);
    push_grant(0, 3, 3, 0);
    push_grant(0, 0, 3, 0);
    push_grant(0, 1, 3, 0);
    push_window(0, 64, 0, 8, 1, 0);
    pulse_fe(0);
    repeat (63) tick();
    pulse_fe(0);
    wait_drain("t5b");
    check("t5b_no_restart", wa_s[0], 0);

    // 6: asynchronous reset in the middle of a grant
    set_lat(0, 0, 0, 0, 0);
    pulse_fe(0);
    repeat (3) tick();
    check("t6_pre_grant", grant_s[0], 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("t6_grant", grant_s[0], 0);
    check("t6_window_active", wa_s[0], 0);
    check("t6_frame_count", fc_s[0], 0);
    check("t6_unserved", unserved_s[0], 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    set_lat(0, 3, 3, 3, 3);
    for (int u = 0; u < N; u++) push_grant(0, u, 3, 0);
    push_window(0, 64, 0, 1, 0, 0);
    pulse_fe(0);
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
Sequences the game-logic units against the VGA frame timing. On each frame-end pulse from the sync generator it opens a bounded update window and shares that window between N_REQ logic units. Arbitration is round-robin, one slot per unit per frame, and each slot is time-limited. The block sits between the sync generator and the game-logic units, so unit state never changes while pixels are being drawn.

Parameters:
N_REQ, 4, number of requesting logic units (2..8)
WINDOW_CYCLES, 32000, length of the update window in clk cycles (fits inside 640x480 vertical blanking)
SLOT_MAX, 4096, maximum clk cycles a single grant may be held
FC_WIDTH, 8, width of frame counter

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high; clears all state
frame_end  in  1  one-cycle pulse from sync generator at the start of blanking
req  in  N_REQ  per-unit update request, level
done  in  N_REQ  per-unit completion pulse; only the bit of the granted unit is honoured
grant  out  N_REQ  one-hot or zero; registered
window_active  out  1  high while the update window is open
frame_start  out  1  one-cycle pulse on the first window cycle
frame_count  out  FC_WIDTH  frames seen, wraps modulo 2^FC_WIDTH
slot_timeout  out  1  one-cycle pulse when a grant is revoked without done
frame_overrun  out  1  one-cycle pulse when frame_end arrives while not IDLE
unserved  out  N_REQ  units still requesting but not served when the last window closed

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0, served=0, all counters 0.
- States: IDLE, ARB, GRANT.
- IDLE:
  - frame_end=1 -> ARB next cycle.
  - On entering ARB: window_active=1, frame_start=1 for that cycle only, win_cnt=0, served=0.
  - frame_count increments on every sampled frame_end, in any state.
- win_cnt increments every cycle in ARB/GRANT. When win_cnt==WINDOW_CYCLES-1 the window closes:
  - next state IDLE, window_active=0, grant=0.
  - unserved <= req & ~served, sampled that cycle.
- ARB:
  - eligible = req & ~served.
  - If eligible is non-zero, the first set bit searching upward from rr_ptr, wrapping, is chosen.
  - grant for that unit asserts on the next cycle (state GRANT), slot_cnt=0, rr_ptr <= chosen+1 mod N_REQ.
  - If eligible is zero, stay in ARB.
  - rr_ptr persists across frames.
- GRANT:
  - slot_cnt increments each cycle while grant is high.
  - done[g]=1 -> served[g]=1, grant drops next cycle, back to ARB. There is a minimum one-cycle gap between grants.
  - slot_cnt==SLOT_MAX-1 with no done -> slot_timeout pulse, served[g]=1, grant drops, back to ARB.
  - Window close while in GRANT -> grant drops, slot_timeout pulses, served not set for g, then IDLE.
  - done for non-granted units is ignored.
  - Deasserting req during a grant has no effect; the unit must still pulse done or time out.
- Simultaneous events:
  - done and window close in the same cycle: done wins (served set, no timeout), still go IDLE.
  - done and slot limit in the same cycle: done wins.
  - frame_end while in ARB/GRANT: window not restarted, frame_overrun pulses, frame_count still increments.
  - frame_end and window close in the same cycle: window closes to IDLE, frame_overrun pulses, and the new frame_end is not re-used.
- Each unit receives at most one grant per window.
- grant is never multi-hot and is always 0 outside the window.
- Async reset mid-window drops grant and window_active immediately.

Test Plan:
1. N_REQ=4, WINDOW_CYCLES=64, SLOT_MAX=8; req=4'b1111, each unit pulses done 3 cycles after its grant -> grant order 0,1,2,3; each grant high 3 cycles; 1-cycle gaps; first grant 2 cycles after frame_end; unserved=0; frame_count=1.
2. Same setup, unit 1 never pulses done -> grant[1] high exactly 8 cycles, slot_timeout pulses once, grant[2] follows after a 1-cycle gap.
3. Last grant was unit 2, next frame req=4'b1011 -> first grant is unit 3, then 0, then 1.
4. WINDOW_CYCLES=16, req=4'b0011, done never asserted -> unit 0 times out at 8 cycles, unit 1 is revoked at window close with a slot_timeout pulse; unserved=4'b0010; window_active low after 16 cycles.
5. frame_end pulsed again 10 cycles into an open window -> frame_overrun pulses, frame_count=2, window still closes at the original cycle 64.
6. Reset asserted mid-GRANT -> grant, window_active, frame_count and unserved all 0 without waiting for a clk edge; after release, the next frame_end starts a clean window with rr_ptr=0.
